// File: rtl/lsu_axi_master_if.sv
// Core-side request/response and AXI4-Lite bus bundle for lsu_axi_master.
// master: the LSU's view; slave: the core + RAM environment's view.
interface lsu_axi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        input  arready, rdata, rvalid, awready, wready, bresp, bvalid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        output arready, rdata, rvalid, awready, wready, bresp, bvalid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/lsu_axi_master.sv
// RV32 load/store unit: one core request at a time -> one AXI4-Lite read or write.
// Define LSU_MISALIGN_CHECK_EN to fail misaligned H/W accesses without bus traffic.
module lsu_axi_master (
    input  logic             clk,
    input  logic             rst,
    lsu_axi_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_e;

    state_e      state_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic [31:0] araddr_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic [31:0] ld_shift;
    logic [31:0] ld_data_d;
    logic        misalign_d;
    logic        aw_fin;
    logic        w_fin;

    // Store lane replication and strobes, computed from the live request in IDLE.
    always_comb begin
        wdata_d = bus.req_wdata;
        wstrb_d = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                wdata_d = {4{bus.req_wdata[7:0]}};
                wstrb_d = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                wdata_d = {2{bus.req_wdata[15:0]}};
                wstrb_d = 4'b0011 << bus.req_addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = bus.rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   ld_data_d = funct3_q[2] ? {24'h0, ld_shift[7:0]}
                                             : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data_d = funct3_q[2] ? {16'h0, ld_shift[15:0]}
                                             : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_d = ld_shift;
        endcase
    end

    always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_d = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_funct3[1] && (bus.req_addr[1:0] != 2'b00));
`else
        misalign_d = 1'b0;
`endif
    end

    // A channel counts as finished if it completed earlier or handshakes this edge.
    assign aw_fin = aw_done_q || (awvalid_q && bus.awready);
    assign w_fin  = w_done_q  || (wvalid_q  && bus.wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= '0;
            funct3_q     <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q    <= bus.req_addr[1:0];
                        funct3_q <= bus.req_funct3;
                        if (misalign_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (bus.req_we) begin
                            state_q   <= WR_REQ;
                            awaddr_q  <= {bus.req_addr[31:2], 2'b00};
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= RD_ADDR;
                            araddr_q  <= {bus.req_addr[31:2], 2'b00};
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data_d;
                        resp_err_q   <= 1'b0;
                        state_q      <= RESP;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && bus.awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && bus.wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= (bus.bresp != 2'b00);
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.awaddr     = awaddr_q;
    assign bus.awvalid    = awvalid_q;
    assign bus.wdata      = wdata_q;
    assign bus.wstrb      = wstrb_q;
    assign bus.wvalid     = wvalid_q;
    assign bus.bready     = bready_q;
endmodule
